// File: rtl/inst_dec_stage.sv
// RV32I decode stage: DEPTH-entry instruction queue with empty-queue bypass and a registered decode bundle.
// Define INST_DEC_STAGE_RV32M_EN to decode the M extension (mul/div/rem); otherwise funct7=0000001 is illegal.
module inst_dec_stage #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int XLEN  = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_flush,
  input  logic            i_inst_valid,
  output logic            o_inst_ready,
  input  logic [31:0]     i_inst_data,
  input  logic [PC_W-1:0] i_pc,
  output logic            o_dec_valid,
  input  logic            i_dec_ready,
  output logic [PC_W-1:0] o_pc,
  output logic [4:0]      o_rd,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_funct3,
  output logic [2:0]      o_op_mode,
  output logic [2:0]      o_func_op,
  output logic            o_unsigned,
  output logic            o_alusrc,
  output logic            o_mem_to_reg,
  output logic            o_reg_write,
  output logic            o_mem_read,
  output logic            o_mem_write,
  output logic            o_branch,
  output logic            o_jump,
  output logic            o_illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = PC_W + 32;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] MODE_NONE  = 3'd0;
  localparam logic [2:0] MODE_LOGIC = 3'd1;
  localparam logic [2:0] MODE_SHIFT = 3'd2;
  localparam logic [2:0] MODE_CMP   = 3'd3;
  localparam logic [2:0] MODE_ADD   = 3'd4;
`ifdef INST_DEC_STAGE_RV32M_EN
  localparam logic [6:0] F7_MULDIV = 7'b0000001;
  localparam logic [2:0] MODE_MUL  = 3'd5;
  localparam logic [2:0] MODE_DIV  = 3'd6;
  localparam logic [2:0] MODE_REM  = 3'd7;
`endif

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic [2:0]  op_mode;
    logic [2:0]  func_op;
    logic        is_unsigned;
    logic        alusrc;
    logic        mem_to_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;
  } dec_t;

  // ---------------------------------------------------------------------------
  // Instruction queue
  // ---------------------------------------------------------------------------
  logic [EW-1:0]   r_fifo_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic            w_can_push;
  logic            w_push;
  logic            w_out_free;
  logic            w_fifo_empty;
  logic            w_pop;
  logic            w_bypass;
  logic            w_fifo_wr;
  logic            w_load;
  logic [EW-1:0]   w_head;
  logic [EW-1:0]   w_sel_word;
  logic [PC_W-1:0] w_sel_pc;
  logic [31:0]     w_sel_inst;

  assign w_can_push   = (r_count < DEPTH_C);
  assign o_inst_ready = w_can_push;
  assign w_push       = i_inst_valid && w_can_push && !i_flush;
  assign w_out_free   = !o_dec_valid || i_dec_ready;
  assign w_fifo_empty = (r_count == '0);
  assign w_pop        = !w_fifo_empty && w_out_free && !i_flush;
  // An empty queue with a free output register lets the incoming word skip the queue.
  assign w_bypass     = w_push && w_fifo_empty && w_out_free;
  assign w_fifo_wr    = w_push && !w_bypass;
  assign w_load       = w_pop || w_bypass;

  assign w_head     = r_fifo_mem[r_rd_ptr];
  assign w_sel_word = w_pop ? w_head : {i_pc, i_inst_data};
  assign w_sel_pc   = w_sel_word[EW-1:32];
  assign w_sel_inst = w_sel_word[31:0];

  always_ff @(posedge i_clk) begin
    if (w_fifo_wr) begin
      r_fifo_mem[r_wr_ptr] <= {i_pc, i_inst_data};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_fifo_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_fifo_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Decode of the selected word
  // ---------------------------------------------------------------------------
  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [4:0]  w_rd_f;
  logic [4:0]  w_rs1_f;
  logic [4:0]  w_rs2_f;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm_u;
  logic [31:0] w_imm_j;
  logic        w_bad;
  dec_t        w_dec;

  assign w_opc   = w_sel_inst[6:0];
  assign w_rd_f  = w_sel_inst[11:7];
  assign w_f3    = w_sel_inst[14:12];
  assign w_rs1_f = w_sel_inst[19:15];
  assign w_rs2_f = w_sel_inst[24:20];
  assign w_f7    = w_sel_inst[31:25];

  assign w_imm_i = {{20{w_sel_inst[31]}}, w_sel_inst[31:20]};
  assign w_imm_s = {{20{w_sel_inst[31]}}, w_sel_inst[31:25], w_sel_inst[11:7]};
  assign w_imm_b = {{19{w_sel_inst[31]}}, w_sel_inst[31], w_sel_inst[7],
                    w_sel_inst[30:25], w_sel_inst[11:8], 1'b0};
  assign w_imm_u = {w_sel_inst[31:12], 12'b0};
  assign w_imm_j = {{11{w_sel_inst[31]}}, w_sel_inst[31], w_sel_inst[19:12],
                    w_sel_inst[20], w_sel_inst[30:21], 1'b0};

  // Shared OP/OP-IMM ALU class; returns {unsigned, op_mode, func_op}. alt selects SUB or SRA.
  function automatic logic [6:0] alu_base(input logic [2:0] f3, input logic alt);
    logic [6:0] r;
    case (f3)
      3'd0:    r = {1'b0, MODE_ADD, {2'b00, alt}};
      3'd1:    r = {1'b0, MODE_SHIFT, 3'd0};
      3'd2:    r = {1'b0, MODE_CMP, 3'd2};
      3'd3:    r = {1'b1, MODE_CMP, 3'd3};
      3'd5:    r = {1'b0, MODE_SHIFT, (alt ? 3'd2 : 3'd1)};
      default: r = {1'b0, MODE_LOGIC, f3};
    endcase
    return r;
  endfunction

  always_comb begin
    w_dec        = '0;
    w_dec.funct3 = w_f3;
    w_bad        = 1'b0;
    case (w_opc)
      OPC_LUI, OPC_AUIPC: begin
        w_dec.rd        = w_rd_f;
        w_dec.imm       = w_imm_u;
        w_dec.op_mode   = MODE_ADD;
        w_dec.alusrc    = 1'b1;
        w_dec.reg_write = 1'b1;
      end
      OPC_JAL: begin
        w_dec.rd        = w_rd_f;
        w_dec.imm       = w_imm_j;
        w_dec.op_mode   = MODE_ADD;
        w_dec.alusrc    = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.jump      = 1'b1;
      end
      OPC_JALR: begin
        w_dec.rd        = w_rd_f;
        w_dec.rs1       = w_rs1_f;
        w_dec.imm       = w_imm_i;
        w_dec.op_mode   = MODE_ADD;
        w_dec.alusrc    = 1'b1;
        w_dec.reg_write = 1'b1;
        w_dec.jump      = 1'b1;
        w_bad           = (w_f3 != 3'd0);
      end
      OPC_BRANCH: begin
        w_dec.rs1         = w_rs1_f;
        w_dec.rs2         = w_rs2_f;
        w_dec.imm         = w_imm_b;
        w_dec.op_mode     = MODE_CMP;
        w_dec.func_op     = w_f3;
        w_dec.is_unsigned = w_f3[2] & w_f3[1];
        w_dec.branch      = 1'b1;
        w_bad             = (w_f3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        w_dec.rd         = w_rd_f;
        w_dec.rs1        = w_rs1_f;
        w_dec.imm        = w_imm_i;
        w_dec.op_mode    = MODE_ADD;
        w_dec.alusrc     = 1'b1;
        w_dec.reg_write  = 1'b1;
        w_dec.mem_read   = 1'b1;
        w_dec.mem_to_reg = 1'b1;
        w_bad            = (w_f3 == 3'd3) || (w_f3[2:1] == 2'b11);
      end
      OPC_STORE: begin
        w_dec.rs1       = w_rs1_f;
        w_dec.rs2       = w_rs2_f;
        w_dec.imm       = w_imm_s;
        w_dec.op_mode   = MODE_ADD;
        w_dec.alusrc    = 1'b1;
        w_dec.mem_write = 1'b1;
        w_bad           = (w_f3 > 3'd2);
      end
      OPC_OPIMM: begin
        w_dec.rd        = w_rd_f;
        w_dec.rs1       = w_rs1_f;
        w_dec.imm       = w_imm_i;
        w_dec.alusrc    = 1'b1;
        w_dec.reg_write = 1'b1;
        {w_dec.is_unsigned, w_dec.op_mode, w_dec.func_op} =
          alu_base(w_f3, (w_f3 == 3'd5) && (w_f7 == F7_ALT));
        // The upper immediate bits act as funct7 only for the shift-immediates.
        w_bad = ((w_f3 == 3'd1) && (w_f7 != F7_BASE)) ||
                ((w_f3 == 3'd5) && (w_f7 != F7_BASE) && (w_f7 != F7_ALT));
      end
      OPC_OP: begin
        w_dec.rd        = w_rd_f;
        w_dec.rs1       = w_rs1_f;
        w_dec.rs2       = w_rs2_f;
        w_dec.reg_write = 1'b1;
        if ((w_f7 == F7_BASE) ||
            ((w_f7 == F7_ALT) && ((w_f3 == 3'd0) || (w_f3 == 3'd5)))) begin
          {w_dec.is_unsigned, w_dec.op_mode, w_dec.func_op} = alu_base(w_f3, w_f7 == F7_ALT);
        end
`ifdef INST_DEC_STAGE_RV32M_EN
        else if (w_f7 == F7_MULDIV) begin
          case (w_f3[2:1])
            2'b10: begin
              w_dec.op_mode     = MODE_DIV;
              w_dec.func_op     = {2'b00, w_f3[0]};
              w_dec.is_unsigned = w_f3[0];
            end
            2'b11: begin
              w_dec.op_mode     = MODE_REM;
              w_dec.func_op     = {2'b00, w_f3[0]};
              w_dec.is_unsigned = w_f3[0];
            end
            default: begin
              w_dec.op_mode = MODE_MUL;
              w_dec.func_op = {1'b0, w_f3[1:0]};
            end
          endcase
        end
`endif
        else begin
          w_bad = 1'b1;
        end
      end
      default: w_bad = 1'b1;
    endcase

    // Illegal words keep their fields and PC for trap handling but must not act.
    if (w_bad) begin
      w_dec.op_mode     = MODE_NONE;
      w_dec.func_op     = 3'd0;
      w_dec.is_unsigned = 1'b0;
      w_dec.alusrc      = 1'b0;
      w_dec.mem_to_reg  = 1'b0;
      w_dec.reg_write   = 1'b0;
      w_dec.mem_read    = 1'b0;
      w_dec.mem_write   = 1'b0;
      w_dec.branch      = 1'b0;
      w_dec.jump        = 1'b0;
    end
    w_dec.illegal = w_bad;
  end

  // ---------------------------------------------------------------------------
  // Output bundle register; only reloaded when empty or being consumed.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_dec_valid  <= 1'b0;
      o_pc         <= '0;
      o_rd         <= '0;
      o_rs1        <= '0;
      o_rs2        <= '0;
      o_imm        <= '0;
      o_funct3     <= '0;
      o_op_mode    <= '0;
      o_func_op    <= '0;
      o_unsigned   <= 1'b0;
      o_alusrc     <= 1'b0;
      o_mem_to_reg <= 1'b0;
      o_reg_write  <= 1'b0;
      o_mem_read   <= 1'b0;
      o_mem_write  <= 1'b0;
      o_branch     <= 1'b0;
      o_jump       <= 1'b0;
      o_illegal    <= 1'b0;
    end else if (i_flush) begin
      o_dec_valid <= 1'b0;
    end else if (w_load) begin
      o_dec_valid  <= 1'b1;
      o_pc         <= w_sel_pc;
      o_rd         <= w_dec.rd;
      o_rs1        <= w_dec.rs1;
      o_rs2        <= w_dec.rs2;
      o_imm        <= XLEN'($signed(w_dec.imm));
      o_funct3     <= w_dec.funct3;
      o_op_mode    <= w_dec.op_mode;
      o_func_op    <= w_dec.func_op;
      o_unsigned   <= w_dec.is_unsigned;
      o_alusrc     <= w_dec.alusrc;
      o_mem_to_reg <= w_dec.mem_to_reg;
      o_reg_write  <= w_dec.reg_write;
      o_mem_read   <= w_dec.mem_read;
      o_mem_write  <= w_dec.mem_write;
      o_branch     <= w_dec.branch;
      o_jump       <= w_dec.jump;
      o_illegal    <= w_dec.illegal;
    end else if (i_dec_ready) begin
      o_dec_valid <= 1'b0;
    end
  end

endmodule
